alu_op_sequencer: RTL and testbench

Registered, handshaked ALU-operation decoder for the processor datapath. It turns an instruction's format field `op1` and operation field `op3` into a stream of ALU commands. Shift instructions are expanded into one single-bit shift beat per position, so the ALU needs only a 1-bit shifter. It sits between the decode stage and the ALU and replaces the purely combinational ALU controller.

---
 rtl/alu_op_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU-operation sequencer: decodes op1/op3 into handshaked ALU command beats.
// Define ALU_SHIFT_SEQ_EN to expand shifts into one single-bit beat per position.
module alu_op_sequencer #(
  parameter int AMT_W = 4,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op1,
  input  logic [OP_W-1:0]  op3,
  input  logic [AMT_W-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  op_out,
  output logic [AMT_W-1:0] amt_out,
  output logic             last_out,
  output logic             busy
);

`ifdef ALU_SHIFT_SEQ_EN
  typedef enum logic [1:0] {IDLE = 2'b00, SINGLE = 2'b01, SEQ = 2'b10} state_t;
  logic [AMT_W-1:0] rem_r;
  logic [AMT_W-1:0] rem_nxt_s;
`else
  typedef enum logic [1:0] {IDLE = 2'b00, SINGLE = 2'b01} state_t;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [OP_W-1:0]  op_nxt_s;
  logic [AMT_W-1:0] amt_nxt_s;
  logic             last_nxt_s;
  logic             accept_s;
  logic             is_shift_s;
  logic [OP_W-1:0]  dec_op_s;

  // Handshake and decode, combinational from registers plus out_ready/flush.
  always_comb begin
    out_valid  = (state_r != IDLE);
    in_ready   = !flush && (!out_valid || (out_ready && last_out));
    accept_s   = in_valid && in_ready;
    is_shift_s = (op1 == 2'b11) && (op3[3:2] == 2'b10);
    dec_op_s   = (op1 == 2'b11) ? op3 : {OP_W{1'b0}};
`ifdef ALU_SHIFT_SEQ_EN
    busy       = (state_r == SEQ) && !last_out;
`else
    busy       = 1'b0;
`endif
  end

  // Next-state and next-beat selection; flush outranks accept and consume.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_out;
    amt_nxt_s   = amt_out;
    last_nxt_s  = last_out;
`ifdef ALU_SHIFT_SEQ_EN
    rem_nxt_s   = rem_r;
`endif
    if (flush) begin
      state_nxt_s = IDLE;
`ifdef ALU_SHIFT_SEQ_EN
      rem_nxt_s   = {AMT_W{1'b0}};
`endif
    end else if (accept_s) begin
      op_nxt_s = dec_op_s;
`ifdef ALU_SHIFT_SEQ_EN
      if (is_shift_s && (d != {AMT_W{1'b0}})) begin
        state_nxt_s = SEQ;
        amt_nxt_s   = AMT_W'(1);
        rem_nxt_s   = d - AMT_W'(1);
        last_nxt_s  = (d == AMT_W'(1));
      end else begin
        state_nxt_s = SINGLE;
        amt_nxt_s   = d;
        rem_nxt_s   = {AMT_W{1'b0}};
        last_nxt_s  = 1'b1;
      end
`else
      state_nxt_s = SINGLE;
      amt_nxt_s   = d;
      last_nxt_s  = 1'b1;
`endif
    end else if (out_valid && out_ready) begin
      if (last_out) begin
        state_nxt_s = IDLE;
      end else begin
`ifdef ALU_SHIFT_SEQ_EN
        rem_nxt_s  = rem_r - AMT_W'(1);
        last_nxt_s = (rem_r == AMT_W'(1));
`else
        last_nxt_s = 1'b1;
`endif
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output beat registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      op_out   <= {OP_W{1'b0}};
      amt_out  <= {AMT_W{1'b0}};
      last_out <= 1'b0;
`ifdef ALU_SHIFT_SEQ_EN
      rem_r    <= {AMT_W{1'b0}};
`endif
    end else begin
      state_r  <= state_nxt_s;
      op_out   <= op_nxt_s;
      amt_out  <= amt_nxt_s;
      last_out <= last_nxt_s;
`ifdef ALU_SHIFT_SEQ_EN
      rem_r    <= rem_nxt_s;
`endif
    end
  end

  // is_shift_s only steers beat expansion when the sequencer is built in.
`ifndef ALU_SHIFT_SEQ_EN
  logic unused_s;
  assign unused_s = is_shift_s;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed instructions push expected
// beats into a queue, a monitor pops and compares each presented beat.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op1 = 2'b00;
  logic [3:0] op3 = 4'b0000;
  logic [3:0] d = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] op_out;
  logic [3:0] amt_out;
  logic       last_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int popped = 0;

`ifdef ALU_SHIFT_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] amt;
    logic       last;
    logic       busy;
  } beat_t;

  beat_t sb[$];

  alu_op_sequencer #(.AMT_W(4), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op1(op1), .op3(op3), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .op_out(op_out),
    .amt_out(amt_out), .last_out(last_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats for one instruction, written from the decode/expansion rules.
  task automatic push_expect(input logic [1:0] p1, input logic [3:0] p3, input logic [3:0] pd);
    beat_t b;
    logic [3:0] op;
    logic shift;
    op    = (p1 == 2'b11) ? p3 : 4'b0000;
    shift = (p1 == 2'b11) && (p3[3:2] == 2'b10);
    if (SEQ_EN && shift && (pd != 4'd0)) begin
      for (int i = 1; i <= int'(pd); i++) begin
        b.op = op; b.amt = 4'd1; b.last = (i == int'(pd)); b.busy = (i != int'(pd));
        sb.push_back(b);
      end
    end else begin
      b.op = op; b.amt = pd; b.last = 1'b1; b.busy = 1'b0;
      sb.push_back(b);
    end
  endtask

  task automatic send(input logic [1:0] p1, input logic [3:0] p3, input logic [3:0] pd);
    bit acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op1 = p1; op3 = p3; d = pd;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        push_expect(p1, p3, pd);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int target;
    target = popped + n;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #3;
      if (popped >= target) break;
    end
    chk("beat_wait", 32'(popped >= target), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every presented beat against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {28'd0, op_out}, 32'hFFFF);
        end else begin
          chk("op_out", {28'd0, op_out}, {28'd0, sb[0].op});
          chk("amt_out", {28'd0, amt_out}, {28'd0, sb[0].amt});
          chk("last_out", {31'd0, last_out}, {31'd0, sb[0].last});
          chk("busy", {31'd0, busy}, {31'd0, sb[0].busy});
          chk("in_ready_busy", {31'd0, in_ready}, {31'd0, !flush && out_ready && sb[0].last});
          if (out_ready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end else begin
        chk("in_ready_idle", {31'd0, in_ready}, {31'd0, !flush});
        chk("busy_idle", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_out", {28'd0, op_out}, 32'd0);
    chk("rst_amt_out", {28'd0, amt_out}, 32'd0);
    chk("rst_last_out", {31'd0, last_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Non-arithmetic format decodes to ADD.
    send(2'b10, 4'b0110, 4'd2);
    idle();
    drain();
    // Back-to-back SUB then XOR with no bubble.
    send(2'b11, 4'b0001, 4'd0);
    send(2'b11, 4'b0100, 4'd9);
    idle();
    drain();
    // Shift-like op3 under another format is still ADD, amt = d.
    send(2'b01, 4'b1000, 4'd6);
    // SRA d=3, immediately followed by SUB once the last beat goes.
    send(2'b11, 4'b1011, 4'd3);
    send(2'b11, 4'b0001, 4'd4);
    // Shift edge amounts: d=0 and d=1.
    send(2'b11, 4'b1001, 4'd0);
    send(2'b11, 4'b1010, 4'd1);
    idle();
    drain();

    // SRA d=3 with two cycles of backpressure at beat 2.
    send(2'b11, 4'b1011, 4'd3);
    idle();
    wait_beats(1);
    @(negedge clk); out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    drain();

    // SLL d=5, flush during beat 2.
    send(2'b11, 4'b1000, 4'd5);
    idle();
    wait_beats(1);
    @(negedge clk); flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    sb.delete();
    @(negedge clk); flush = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    send(2'b11, 4'b0010, 4'd3);
    idle();
    drain();

    // SLL d=7, asynchronous reset mid-cycle around beat 4.
    send(2'b11, 4'b1000, 4'd7);
    idle();
    wait_beats(SEQ_EN ? 4 : 1);
    #1 reset = 1'b1;
    #1;
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_op_out", {28'd0, op_out}, 32'd0);
    chk("areset_amt_out", {28'd0, amt_out}, 32'd0);
    chk("areset_last_out", {31'd0, last_out}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    send(2'b11, 4'b0001, 4'd5);
    idle();
    drain();

    repeat (5) @(negedge clk);
    chk("final_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", {31'd0, out_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
